// File: rtl/perceptron_trainer.sv
// Sequential single-neuron perceptron: one MAC per cycle, threshold, and a
// serial saturating perceptron update when training on a misclassified sample.
//
// state | meaning
// IDLE  | waiting for a sample or a weight write
// MAC   | accumulating w[i]*x[i], one feature per cycle
// ACT   | threshold, result strobe, epoch bookkeeping
// UPD   | writing back w[0..N_IN-1] then the bias, one per cycle
module perceptron_trainer #(
  parameter int N_IN     = 4,
  parameter int DATA_W   = 8,
  parameter int W_W      = 8,
  parameter int LR_SHIFT = 0,
  parameter int ACC_W    = W_W + DATA_W + $clog2(N_IN + 1) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [N_IN*DATA_W-1:0]        s_x,
  input  logic                          s_label,
  input  logic                          s_last,
  input  logic                          wr_en,
  input  logic [$clog2(N_IN+1)-1:0]     wr_idx,
  input  logic [W_W-1:0]                wr_data,
  input  logic [$clog2(N_IN+1)-1:0]     rd_idx,
  output logic [W_W-1:0]                rd_data,
  output logic                          o_valid,
  output logic                          o_pred,
  output logic signed [1:0]             o_err,
  output logic [15:0]                   epoch_errs,
  output logic                          converged
);

  localparam int IDX_W  = $clog2(N_IN + 1);
  localparam int PROD_W = W_W + DATA_W;
  localparam int SUM_W  = ((W_W > DATA_W) ? W_W : DATA_W) + 2;
  localparam logic [IDX_W-1:0] BIAS_IDX = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST_X   = IDX_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = '0;
  localparam logic signed [SUM_W-1:0] W_MAX = SUM_W'((2 ** (W_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] W_MIN = SUM_W'(-(2 ** (W_W - 1)));
  localparam logic signed [SUM_W-1:0] SUM_ONE = SUM_W'(1);

  typedef enum logic [1:0] {IDLE, MAC, ACT, UPD} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  // Entries 0..N_IN-1 are feature weights, entry N_IN is the bias.
  logic signed [W_W-1:0]     w [N_IN+1];
  logic signed [ACC_W-1:0]   acc;
  // Captured features; rotated one slot per MAC/UPD cycle so slot 0 is current.
  logic [N_IN*DATA_W-1:0]    x_sh;
  logic                      label_r;
  logic                      last_r;
  logic                      mode_r;
  logic                      err_neg;
  logic [15:0]               err_cnt;

  logic [N_IN*DATA_W-1:0]    x_rot;
  logic signed [DATA_W-1:0]  x_cur;
  logic signed [DATA_W-1:0]  step_x;
  logic signed [W_W-1:0]     w_sel;
  logic signed [PROD_W-1:0]  prod;
  logic                      pred;
  logic                      err_hit;
  logic [15:0]               cnt_next;
  logic signed [SUM_W-1:0]   step_ext;
  logic signed [SUM_W-1:0]   upd_sum;
  logic signed [W_W-1:0]     w_sat;

  assign s_ready = (state == IDLE) && !wr_en;
  assign rd_data = (rd_idx <= BIAS_IDX) ? w[rd_idx] : '0;

  assign x_rot  = (x_sh >> DATA_W) | (x_sh << ((N_IN - 1) * DATA_W));
  assign x_cur  = x_sh[DATA_W-1:0];
  assign step_x = x_cur >>> LR_SHIFT;
  assign w_sel  = w[idx];
  assign prod   = PROD_W'(w_sel) * PROD_W'(x_cur);
  assign pred   = (acc > ACC_ZERO);
  assign err_hit = mode_r && (label_r != pred);

  // Saturating error counter value including the sample now in ACT.
  always_comb begin
    cnt_next = err_cnt;
    if (err_hit && (err_cnt != 16'hFFFF)) cnt_next = err_cnt + 16'd1;
  end

  // Update step for the current index: +/- feature for weights, +/-1 for bias, then clamp.
  always_comb begin
    step_ext = (idx == BIAS_IDX) ? SUM_ONE : SUM_W'(step_x);
    upd_sum  = err_neg ? (SUM_W'(w_sel) - step_ext) : (SUM_W'(w_sel) + step_ext);
    if (upd_sum > W_MAX)      w_sat = W_MAX[W_W-1:0];
    else if (upd_sum < W_MIN) w_sat = W_MIN[W_W-1:0];
    else                      w_sat = upd_sum[W_W-1:0];
  end

  // Control FSM with datapath, weight storage and registered result/epoch outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      x_sh       <= '0;
      label_r    <= 1'b0;
      last_r     <= 1'b0;
      mode_r     <= 1'b0;
      err_neg    <= 1'b0;
      err_cnt    <= '0;
      o_valid    <= 1'b0;
      o_pred     <= 1'b0;
      o_err      <= '0;
      epoch_errs <= '0;
      converged  <= 1'b0;
      for (int i = 0; i <= N_IN; i++) w[i] <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) begin
            if (wr_idx <= BIAS_IDX) w[wr_idx] <= wr_data;
          end else if (s_valid) begin
            x_sh    <= s_x;
            label_r <= s_label;
            last_r  <= s_last;
            mode_r  <= mode;
            acc     <= ACC_W'(w[BIAS_IDX]);
            idx     <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          acc  <= acc + ACC_W'(prod);
          x_sh <= x_rot;
          if (idx == LAST_X) begin
            idx   <= '0;
            state <= ACT;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ACT: begin
          o_valid <= 1'b1;
          o_pred  <= pred;
          if (err_hit) begin
            o_err   <= label_r ? 2'sb01 : 2'sb11;
            err_neg <= !label_r;
            state   <= UPD;
          end else begin
            o_err <= '0;
            state <= IDLE;
          end
          if (mode_r) begin
            if (last_r) begin
              epoch_errs <= cnt_next;
              if (cnt_next == 16'd0) converged <= 1'b1;
              err_cnt <= '0;
            end else begin
              err_cnt <= cnt_next;
            end
          end
        end
        UPD: begin
          w[idx] <= w_sat;
          x_sh   <= x_rot;
          if (idx == BIAS_IDX) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: directed scenarios plus randomized samples,
// compared against an arithmetic reference model of the perceptron.
module tb_perceptron_trainer;

  localparam int N_IN     = 2;
  localparam int DATA_W   = 8;
  localparam int W_W      = 8;
  localparam int LR_SHIFT = 0;
  localparam int IDX_W    = $clog2(N_IN + 1);
  localparam int XW       = N_IN * DATA_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             s_valid;
  logic             s_ready;
  logic [XW-1:0]    s_x;
  logic             s_label;
  logic             s_last;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [W_W-1:0]   wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [W_W-1:0]   rd_data;
  logic             o_valid;
  logic             o_pred;
  logic [1:0]       o_err;
  logic [15:0]      epoch_errs;
  logic             converged;

  perceptron_trainer #(
    .N_IN(N_IN), .DATA_W(DATA_W), .W_W(W_W), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_label(s_label), .s_last(s_last), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .rd_idx(rd_idx), .rd_data(rd_data),
    .o_valid(o_valid), .o_pred(o_pred), .o_err(o_err),
    .epoch_errs(epoch_errs), .converged(converged)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state.
  int mw[N_IN+1];
  int xs[N_IN];
  int m_errcnt, m_epoch, m_conv;
  int exp_pred, exp_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    int hi, lo;
    hi = (1 <<< (W_W - 1)) - 1;
    lo = -(1 <<< (W_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N_IN; i++) mw[i] = 0;
    m_errcnt = 0;
    m_epoch  = 0;
    m_conv   = 0;
  endtask

  task automatic model_sample(input int label, input int md, input int last);
    int acc, pred, err;
    acc = mw[N_IN];
    for (int i = 0; i < N_IN; i++) acc += mw[i] * xs[i];
    pred = (acc > 0) ? 1 : 0;
    err  = (md != 0) ? (label - pred) : 0;
    if (md != 0) begin
      if (err != 0 && m_errcnt < 65535) m_errcnt++;
      if (last != 0) begin
        m_epoch = m_errcnt;
        if (m_errcnt == 0) m_conv = 1;
        m_errcnt = 0;
      end
    end
    if (err != 0) begin
      for (int i = 0; i < N_IN; i++) mw[i] = sat(mw[i] + err * (xs[i] >>> LR_SHIFT));
      mw[N_IN] = sat(mw[N_IN] + err);
    end
    exp_pred = pred;
    exp_err  = err;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i <= N_IN; i++) begin
      rd_idx = IDX_W'(i);
      #1;
      chk($sformatf("%s_w%0d", tag, i), int'($signed(rd_data)), mw[i]);
    end
    chk({tag, "_epoch_errs"}, int'(epoch_errs), m_epoch);
    chk({tag, "_converged"}, int'(converged), m_conv);
  endtask

  task automatic wr_w(input int idx, input int data);
    wr_en   = 1'b1;
    wr_idx  = IDX_W'(idx);
    wr_data = W_W'(data);
    #1;
    chk("wr_blocks_ready", int'(s_ready), 0);
    step();
    wr_en = 1'b0;
    if (idx <= N_IN) begin
      mw[idx] = data;
      rd_idx = IDX_W'(idx);
      #1;
      chk("wr_readback", int'($signed(rd_data)), data);
    end
  endtask

  task automatic send_sample(input int x0, input int x1, input int label, input int md,
                             input int last, input int collide, input int cidx, input int cdata);
    int g, k, r, upd;
    bit seen;
    g = 0; k = 0; r = 0; seen = 1'b0;
    while (!s_ready && g < 50) begin step(); g++; end
    if (g >= 50) chk("idle_wait_timeout", 0, 1);
    xs[0] = x0;
    xs[1] = x1;
    s_x     = {DATA_W'(x1), DATA_W'(x0)};
    s_label = label[0];
    mode    = md[0];
    s_last  = last[0];
    s_valid = 1'b1;
    if (collide != 0) begin
      wr_en   = 1'b1;
      wr_idx  = IDX_W'(cidx);
      wr_data = W_W'(cdata);
      #1;
      chk("collide_ready", int'(s_ready), 0);
      step();
      wr_en = 1'b0;
      if (cidx <= N_IN) mw[cidx] = cdata;
      #1;
      chk("collide_no_accept", int'(s_ready), 1);
    end
    step();
    s_valid = 1'b0;
    s_x     = XW'($urandom);
    s_label = 1'($urandom);
    mode    = 1'($urandom);
    s_last  = 1'($urandom);
    model_sample(label, md, last);
    upd = (exp_err != 0) ? 1 : 0;
    while (!seen && k < 20) begin step(); k++; seen = o_valid; end
    chk("ovalid_latency", k, N_IN + 1);
    chk("pred", int'(o_pred), exp_pred);
    chk("err", int'($signed(o_err)), exp_err);
    chk("ready_at_result", int'(s_ready), (upd != 0) ? 0 : 1);
    if (upd != 0) begin
      while (!s_ready && r < 20) begin step(); r++; end
      chk("ready_after_update", k + r, 2 * N_IN + 2);
    end else begin
      step();
    end
    chk("ovalid_one_cycle", int'(o_valid), 0);
    check_state("post");
  endtask

  initial begin
    int k;
    rst = 1'b1; mode = 1'b0; s_valid = 1'b0; s_x = '0; s_label = 1'b0; s_last = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    #1;

    chk("rst_ovalid", int'(o_valid), 0);
    chk("rst_opred", int'(o_pred), 0);
    chk("rst_oerr", int'(o_err), 0);
    chk("rst_ready", int'(s_ready), 1);
    check_state("rst");

    // Infer from zero weights, then train from zero, then a negative update.
    send_sample(3, 5, 1, 0, 0, 0, 0, 0);
    send_sample(3, 5, 1, 1, 0, 0, 0, 0);
    chk("train_w0", mw[0], 3);
    send_sample(2, 1, 0, 1, 0, 0, 0, 0);
    chk("neg_w1", mw[1], 4);

    // Saturation on w0, ordinary step on w1.
    wr_w(0, 127);
    wr_w(1, -128);
    wr_w(2, 0);
    send_sample(10, 10, 1, 1, 0, 0, 0, 0);

    // Write collides with an offered sample: write wins, sample follows.
    send_sample(1, 1, 0, 0, 0, 1, 2, 5);

    // Clean epoch converges; after reset a single wrong sample does not.
    do_reset();
    send_sample(4, -3, 0, 1, 0, 0, 0, 0);
    send_sample(-2, 7, 0, 1, 1, 0, 0, 0);
    chk("epochA_converged", int'(converged), 1);
    do_reset();
    send_sample(1, 1, 1, 1, 1, 0, 0, 0);
    chk("epochB_errs", int'(epoch_errs), 1);
    chk("epochB_converged", int'(converged), 0);

    // Write during MAC is ignored; reset in the middle of the update wipes it.
    do_reset();
    s_x = {8'd5, 8'd3}; s_label = 1'b1; mode = 1'b1; s_last = 1'b0; s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    wr_en = 1'b1; wr_idx = '0; wr_data = 8'd99;
    step();
    wr_en = 1'b0;
    rd_idx = '0;
    #1;
    chk("mac_write_ignored", int'($signed(rd_data)), 0);
    k = 0;
    while (!o_valid && k < 20) begin step(); k++; end
    chk("midupd_ovalid", int'(o_valid), 1);
    step();
    rd_idx = '0;
    #1;
    chk("partial_update_w0", int'($signed(rd_data)), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    #1;
    chk("midupd_rst_ovalid", int'(o_valid), 0);
    chk("midupd_rst_ready", int'(s_ready), 1);
    check_state("midupd_rst");

    // Randomized samples, modes, epochs and occasional writes.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int a, b, lab, md, last, col, cidx;
      byte ba, bb, bc;
      ba = byte'($urandom);
      bb = byte'($urandom);
      bc = byte'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(0, 40)) - 20;
        b = int'($urandom_range(0, 40)) - 20;
      end else begin
        a = ba;
        b = bb;
      end
      lab  = int'($urandom_range(0, 1));
      md   = ($urandom_range(0, 9) < 7) ? 1 : 0;
      last = ($urandom_range(0, 4) == 0) ? 1 : 0;
      col  = ($urandom_range(0, 9) == 0) ? 1 : 0;
      cidx = int'($urandom_range(0, N_IN));
      if ($urandom_range(0, 9) == 0) wr_w(int'($urandom_range(0, 3)), int'(bc));
      send_sample(a, b, lab, md, last, col, cidx, int'(bc));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
